clk_div_prog: RTL and testbench

Programmable integer clock divider, and the parametrised successor to the fixed divide-by-3 toggle divider. It accepts any runtime ratio N from 2 to 2^CNT_W-1. Ratio changes are glitch-free and take effect only at period boundaries. For odd N it can produce a true 50 % duty output by combining a posedge and a negedge term. It also provides a one-cycle tick strobe, aligned to the output period, for clock-enable use in downstream logic on the source clock.

---
 rtl/clk_div_prog_if.sv | 23 ++
 rtl/clk_div_prog.sv | 104 ++++++++++
 tb/tb_clk_div_prog.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - control and status bundle for the programmable clock divider
interface clk_div_prog_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic             duty50;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] div_cur;
  logic             err;

  modport master (
    output en, div_load, div_val, duty50,
    input  clk_out, tick, div_cur, err
  );

  modport slave (
    input  en, div_load, div_val, duty50,
    output clk_out, tick, div_cur, err
  );
endinterface

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable integer clock divider with glitch-free ratio change
module clk_div_prog #(
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  clk_div_prog_if.slave  bus
);

  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(DIV_INIT);
  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] div_act, div_act_nx;
  logic [CNT_W-1:0] div_pend, div_pend_nx;
  logic [CNT_W-1:0] nxt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] last;
  logic [CNT_W:0]   cnt_inc;
  logic             running, running_nx;
  logic             q_p, q_p_nx;
  logic             q_n;
  logic             err_r, err_nx;
  logic             load_ok;
  logic             load_bad;
  logic             at_end;

  // Decode the ratio load and derive period landmarks; half is (N+1)>>1 without a carry bit
  always_comb begin
    load_ok  = bus.div_load && (bus.div_val >= MIN_V);
    load_bad = bus.div_load && (bus.div_val < MIN_V);
    nxt      = load_ok ? bus.div_val : div_pend;
    half     = (div_act >> 1) + {{(CNT_W-1){1'b0}}, div_act[0]};
    last     = div_act - ONE_V;
    at_end   = running && (cnt == last);
    cnt_inc  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  end

  // Next-state: idle / start / boundary / count; a same-cycle legal load wins at a boundary
  always_comb begin
    cnt_nx      = cnt;
    q_p_nx      = q_p;
    running_nx  = running;
    div_act_nx  = div_act;
    div_pend_nx = load_ok ? bus.div_val : div_pend;
    err_nx      = err_r | load_bad;
    if (!bus.en) begin
      cnt_nx     = '0;
      q_p_nx     = 1'b0;
      running_nx = 1'b0;
    end else if (!running) begin
      cnt_nx     = '0;
      q_p_nx     = 1'b1;
      running_nx = 1'b1;
      div_act_nx = nxt;
    end else if (at_end) begin
      cnt_nx     = '0;
      q_p_nx     = 1'b1;
      div_act_nx = nxt;
    end else begin
      cnt_nx = cnt_inc[CNT_W-1:0];
      q_p_nx = (cnt_inc < {1'b0, half});
    end
  end

  // Posedge state register; reset clears immediately so clk_out drops without a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      running  <= 1'b0;
      q_p      <= 1'b0;
      div_act  <= INIT_V;
      div_pend <= INIT_V;
      err_r    <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      running  <= running_nx;
      q_p      <= q_p_nx;
      div_act  <= div_act_nx;
      div_pend <= div_pend_nx;
      err_r    <= err_nx;
    end
  end

  // Half-cycle delayed copy of q_p; ANDing it in trims half a cycle off odd-N high phases
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_n <= 1'b0;
    end else begin
      q_n <= q_p;
    end
  end

  // Outputs derive from flops only; duty50 is read live
  always_comb begin
    bus.clk_out = (bus.duty50 && div_act[0]) ? (q_p & q_n) : q_p;
    bus.tick    = at_end;
    bus.div_cur = div_act;
    bus.err     = err_r;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - scoreboard bench for the programmable clock divider
module tb_clk_div_prog;

  logic clk;
  logic reset_n;

  clk_div_prog_if #(.CNT_W(8)) b8 ();
  clk_div_prog_if #(.CNT_W(4)) b4 ();

  clk_div_prog #(.CNT_W(8), .DIV_INIT(3)) u8 (.clk(clk), .reset_n(reset_n), .bus(b8));
  clk_div_prog #(.CNT_W(4), .DIV_INIT(3)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));

  typedef struct packed {
    logic       hi1;
    logic       hi2;
    logic       tk;
    logic [7:0] cur;
  } exp_t;

  exp_t q[$];
  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle waveform of a period of N, derived from the high/low phase lengths
  task automatic push_period(input int n, input bit duty, input int len);
    exp_t e;
    int h;
    bit eff;
    h   = (n + 1) / 2;
    eff = duty && (n % 2 == 1);
    for (int c = 0; c < len; c++) begin
      e.hi1 = (c < h) && !(eff && c == 0);
      e.hi2 = (c < h);
      e.tk  = (c == n - 1);
      e.cur = 8'(n);
      q.push_back(e);
    end
  endtask

  task automatic push_idle(input int k, input int cur);
    exp_t e;
    for (int c = 0; c < k; c++) begin
      e.hi1 = 1'b0;
      e.hi2 = 1'b0;
      e.tk  = 1'b0;
      e.cur = 8'(cur);
      q.push_back(e);
    end
  endtask

  task automatic run_check(input string name, input bit sel, input int cycles);
    exp_t e;
    logic co;
    logic tk;
    logic [7:0] cur;
    for (int i = 0; i < cycles; i++) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s queue_empty at cycle %0d", name, i);
        return;
      end
      e = q.pop_front();
      @(posedge clk);
      #1;
      co  = sel ? b4.clk_out : b8.clk_out;
      tk  = sel ? b4.tick : b8.tick;
      cur = sel ? {4'b0, b4.div_cur} : b8.div_cur;
      total++;
      if (co !== e.hi1) begin
        bad++;
        $display("FAIL %s clk_out_pos cyc=%0d got=%b want=%b", name, i, co, e.hi1);
      end
      total++;
      if (tk !== e.tk) begin
        bad++;
        $display("FAIL %s tick cyc=%0d got=%b want=%b", name, i, tk, e.tk);
      end
      total++;
      if (cur !== e.cur) begin
        bad++;
        $display("FAIL %s div_cur cyc=%0d got=%0d want=%0d", name, i, cur, e.cur);
      end
      @(negedge clk);
      #1;
      co = sel ? b4.clk_out : b8.clk_out;
      total++;
      if (co !== e.hi2) begin
        bad++;
        $display("FAIL %s clk_out_neg cyc=%0d got=%b want=%b", name, i, co, e.hi2);
      end
    end
  endtask

  task automatic test_reset;
    total++;
    if (b8.clk_out !== 1'b0) begin bad++; $display("FAIL reset clk_out got=%b want=0", b8.clk_out); end
    total++;
    if (b8.tick !== 1'b0) begin bad++; $display("FAIL reset tick got=%b want=0", b8.tick); end
    total++;
    if (b8.div_cur !== 8'd3) begin bad++; $display("FAIL reset div_cur got=%0d want=3", b8.div_cur); end
    total++;
    if (b8.err !== 1'b0) begin bad++; $display("FAIL reset err got=%b want=0", b8.err); end
    total++;
    if (b4.div_cur !== 4'd3) begin bad++; $display("FAIL reset div_cur4 got=%0d want=3", b4.div_cur); end
    push_idle(2, 3);
    run_check("reset_idle", 1'b0, 2);
  endtask

  task automatic test_div3;
    b8.en = 1'b1;
    for (int p = 0; p < 3; p++) push_period(3, 1'b0, 3);
    run_check("div3", 1'b0, 9);
    b8.en = 1'b0;
    push_idle(2, 3);
    run_check("div3_idle", 1'b0, 2);
  endtask

  task automatic test_odd5;
    b8.div_load = 1'b1;
    b8.div_val  = 8'd5;
    b8.duty50   = 1'b1;
    push_idle(1, 3);
    run_check("odd5_load", 1'b0, 1);
    b8.div_load = 1'b0;
    b8.en = 1'b1;
    for (int p = 0; p < 2; p++) push_period(5, 1'b1, 5);
    run_check("odd5_d50", 1'b0, 10);
    b8.en = 1'b0;
    push_idle(1, 5);
    run_check("odd5_idle", 1'b0, 1);
    b8.duty50 = 1'b0;
    b8.en = 1'b1;
    for (int p = 0; p < 2; p++) push_period(5, 1'b0, 5);
    run_check("odd5_d0", 1'b0, 10);
    b8.en = 1'b0;
    push_idle(1, 5);
    run_check("odd5_idle2", 1'b0, 1);
  endtask

  task automatic test_even4;
    b8.div_load = 1'b1;
    b8.div_val  = 8'd4;
    push_idle(1, 5);
    run_check("even4_load", 1'b0, 1);
    b8.div_load = 1'b0;
    b8.en = 1'b1;
    for (int p = 0; p < 2; p++) push_period(4, 1'b0, 4);
    run_check("even4_d0", 1'b0, 8);
    b8.en = 1'b0;
    push_idle(1, 4);
    run_check("even4_idle", 1'b0, 1);
    b8.duty50 = 1'b1;
    b8.en = 1'b1;
    for (int p = 0; p < 2; p++) push_period(4, 1'b1, 4);
    push_period(4, 1'b1, 1);
    run_check("even4_d50", 1'b0, 9);
    b8.en = 1'b0;
    push_idle(2, 4);
    run_check("even4_trunc", 1'b0, 2);
    b8.duty50 = 1'b0;
  endtask

  task automatic test_ratio_change;
    b8.div_load = 1'b1;
    b8.div_val  = 8'd3;
    push_idle(1, 4);
    run_check("chg_load", 1'b0, 1);
    b8.div_load = 1'b0;
    b8.en = 1'b1;
    push_period(3, 1'b0, 3);
    push_period(6, 1'b0, 6);
    push_period(6, 1'b0, 6);
    run_check("chg_a", 1'b0, 2);
    b8.div_load = 1'b1;
    b8.div_val  = 8'd6;
    run_check("chg_b", 1'b0, 1);
    b8.div_load = 1'b0;
    run_check("chg_c", 1'b0, 12);
  endtask

  task automatic test_illegal;
    push_period(6, 1'b0, 6);
    push_period(6, 1'b0, 6);
    b8.div_load = 1'b1;
    b8.div_val  = 8'd1;
    run_check("ill_a", 1'b0, 1);
    total++;
    if (b8.err !== 1'b1) begin bad++; $display("FAIL illegal err_after_1 got=%b want=1", b8.err); end
    b8.div_val = 8'd0;
    run_check("ill_b", 1'b0, 1);
    b8.div_load = 1'b0;
    run_check("ill_c", 1'b0, 10);
    b8.en = 1'b0;
    push_idle(1, 6);
    run_check("ill_idle", 1'b0, 1);
    b8.en = 1'b1;
    push_period(6, 1'b0, 6);
    run_check("ill_restart", 1'b0, 6);
    b8.en = 1'b0;
    push_idle(1, 6);
    run_check("ill_idle2", 1'b0, 1);
    total++;
    if (b8.err !== 1'b1) begin bad++; $display("FAIL illegal err_sticky got=%b want=1", b8.err); end
  endtask

  task automatic test_wide_reset;
    b4.div_load = 1'b1;
    b4.div_val  = 4'd15;
    push_idle(1, 3);
    run_check("w15_load", 1'b1, 1);
    b4.div_load = 1'b0;
    b4.en = 1'b1;
    for (int p = 0; p < 2; p++) push_period(15, 1'b0, 15);
    run_check("w15", 1'b1, 30);
    push_period(15, 1'b0, 4);
    run_check("w15_pre", 1'b1, 3);
    @(posedge clk);
    #2;
    total++;
    if (b4.clk_out !== 1'b1) begin bad++; $display("FAIL arst pre_clk_out got=%b want=1", b4.clk_out); end
    reset_n = 1'b0;
    #1;
    total++;
    if (b4.clk_out !== 1'b0) begin bad++; $display("FAIL arst clk_out got=%b want=0", b4.clk_out); end
    total++;
    if (b4.tick !== 1'b0) begin bad++; $display("FAIL arst tick got=%b want=0", b4.tick); end
    total++;
    if (b4.div_cur !== 4'd3) begin bad++; $display("FAIL arst div_cur got=%0d want=3", b4.div_cur); end
    total++;
    if (b8.err !== 1'b0) begin bad++; $display("FAIL arst err_clear got=%b want=0", b8.err); end
    q.delete();
    #3;
    reset_n = 1'b1;
    push_period(3, 1'b0, 3);
    push_period(3, 1'b0, 3);
    run_check("w_after_rst", 1'b1, 6);
    b4.en = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    b8.en = 1'b0; b8.div_load = 1'b0; b8.div_val = 8'd0; b8.duty50 = 1'b0;
    b4.en = 1'b0; b4.div_load = 1'b0; b4.div_val = 4'd0; b4.duty50 = 1'b0;
    #22;
    reset_n = 1'b1;
    test_reset();
    test_div3();
    test_odd5();
    test_even4();
    test_ratio_change();
    test_illegal();
    test_wide_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
